// File: rtl/aer_pkg.sv
// Shared constants for the AER event path: event word width and default
// FIFO geometry and flag thresholds.
package aer_pkg;

    localparam int AER_EVENT_W   = 24;
    localparam int AER_DEPTH     = 64;
    localparam int AER_AF_THRESH = 56;
    localparam int AER_AE_THRESH = 4;
    localparam int AER_CNT_W     = 16;

endpackage

// File: rtl/aer_fifo_mem.sv
// Flop-array storage for the event FIFO: one synchronous write port and one
// asynchronous read port so the head entry falls through to the output.
module aer_fifo_mem
    import aer_pkg::*;
#(
    parameter int DATA_W = AER_EVENT_W,
    parameter int DEPTH  = AER_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy lives in the pointers, so stale
    // words are never observed. Non-blocking assignment for all clocked state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/aer_event_fifo.sv
// First-word-fall-through event FIFO with occupancy flags, a sticky overflow
// flag and a saturating count of dropped pushes.
module aer_event_fifo
    import aer_pkg::*;
#(
    parameter int DATA_W    = AER_EVENT_W,
    parameter int DEPTH     = AER_DEPTH,
    parameter int AF_THRESH = AER_AF_THRESH,
    parameter int AE_THRESH = AER_AE_THRESH,
    parameter int CNT_W     = AER_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          dout,
    output logic                       out_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_stat
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count_q;
    logic [PW-1:0]    count_d;
    logic             push;
    logic             pop;
    logic             drop;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;

    assign empty        = (count_q == '0);
    assign full         = (count_q == PW'(DEPTH));
    assign out_valid    = !empty;
    assign almost_full  = (count_q >= PW'(AF_THRESH));
    assign almost_empty = (count_q <= PW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign pop  = rd_en && out_valid;
    assign push = wr_en && (!full || pop) && !flush;
    assign drop = wr_en && full && !pop && !flush;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_d;
        end
    end

    // A drop coinciding with clr_stat restarts the statistics at one drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clr_stat) begin
                drop_cnt_q <= CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end else if (clr_stat) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    aer_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (din),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (dout)
    );

endmodule

// File: tb/tb_aer_event_fifo.sv
// Directed bench for aer_event_fifo at DEPTH=8, AF_THRESH=6, AE_THRESH=1, CNT_W=4.
module tb_aer_event_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [23:0] din;
    logic        rd_en;
    logic [23:0] dout;
    logic        out_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic [3:0]  drop_cnt;
    logic        clr_stat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aer_event_fifo #(
        .DATA_W    (24),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1),
        .CNT_W     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .out_valid    (out_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_stat     (clr_stat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_stat = 1'b0; din = '0;
    endtask

    task automatic push_seq(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; din = base + 24'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        checks++;
        if ({empty, almost_empty, full, almost_full, out_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 11000", {empty, almost_empty, full, almost_full, out_valid});
        end
        checks++;
        if (count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_stats got count=%0d ovf=%b drop=%0d exp 0 0 0", count, overflow, drop_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        wr_en = 1'b1; din = 24'h000001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (count !== 4'(i) || full !== (i == 8) || almost_full !== (i >= 6) || almost_empty !== (i <= 1)) begin
                errors++;
                $display("FAIL fill_flags i=%0d got count=%0d full=%b af=%b ae=%b", i, count, full, almost_full, almost_empty);
            end
            checks++;
            if (out_valid !== 1'b1 || dout !== 24'h000001) begin
                errors++;
                $display("FAIL fill_head i=%0d got valid=%b dout=%h exp 1 000001", i, out_valid, dout);
            end
            if (i < 8) din = 24'(i + 1);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; wr_en = 1'b1; din = 24'h0000AA;
            checks++;
            if (dout !== 24'(i + 1)) begin
                errors++;
                $display("FAIL full_rw_order i=%0d got %h exp %h", i, dout, 24'(i + 1));
            end
            tick();
            checks++;
            if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 4'd0) begin
                errors++;
                $display("FAIL full_rw_count i=%0d got count=%0d full=%b ovf=%b drop=%0d exp 8 1 0 0", i, count, full, overflow, drop_cnt);
            end
        end
        idle();
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; din = 24'hBADBAD;
        repeat (20) tick();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 4'd15) begin
            errors++;
            $display("FAIL ovf_saturate got ovf=%b drop=%0d exp 1 15", overflow, drop_cnt);
        end
        checks++;
        if (count !== 4'd8 || dout !== 24'h000004) begin
            errors++;
            $display("FAIL ovf_data got count=%0d dout=%h exp 8 000004", count, dout);
        end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_stat got ovf=%b drop=%0d exp 0 0", overflow, drop_cnt);
        end
        wr_en = 1'b1; clr_stat = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clr_vs_drop got ovf=%b drop=%0d exp 1 1", overflow, drop_cnt);
        end
        tick();
        clr_stat = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_stat2 got ovf=%b drop=%0d exp 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_drain();
        logic [23:0] exp_q [8];
        exp_q = '{24'h4, 24'h5, 24'h6, 24'h7, 24'h8, 24'hAA, 24'hAA, 24'hAA};
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_q[i]) begin
                errors++;
                $display("FAIL drain_order i=%0d got valid=%b dout=%h exp 1 %h", i, out_valid, dout, exp_q[i]);
            end
            tick();
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_empty got count=%0d empty=%b valid=%b exp 0 1 0", count, empty, out_valid);
        end
    endtask

    task automatic test_wrap();
        int  sent = 0;
        int  recv = 0;
        int  mcount = 0;
        bit  mpop, mpush;
        for (int cyc = 0; cyc < 40 && recv < 20; cyc++) begin
            wr_en = (sent < 20);
            din   = 24'h000100 + 24'(sent);
            rd_en = (cyc >= 3);
            mpop  = rd_en && (mcount > 0);
            mpush = wr_en && ((mcount < 8) || mpop);
            if (mpop) begin
                checks++;
                if (out_valid !== 1'b1 || dout !== 24'h000100 + 24'(recv)) begin
                    errors++;
                    $display("FAIL wrap_order n=%0d got valid=%b dout=%h exp 1 %h", recv, out_valid, dout, 24'h000100 + 24'(recv));
                end
                recv++;
            end
            if (mpush) sent++;
            mcount = mcount + int'(mpush) - int'(mpop);
            tick();
            checks++;
            if (count !== 4'(mcount) || count > 4'd8) begin
                errors++;
                $display("FAIL wrap_count cyc=%0d got %0d exp %0d", cyc, count, mcount);
            end
        end
        idle();
        checks++;
        if (recv != 20 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got recv=%0d empty=%b exp 20 1", recv, empty);
        end
    endtask

    task automatic test_flush();
        push_seq(24'h000020, 5);
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL flush_pre got %0d exp 5", count);
        end
        wr_en = 1'b1; rd_en = 1'b1; flush = 1'b1; din = 24'h000099;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_part got count=%0d empty=%b valid=%b drop=%0d exp 0 1 0 0", count, empty, out_valid, drop_cnt);
        end
        push_seq(24'h000040, 8);
        wr_en = 1'b1; flush = 1'b1;
        tick();
        idle();
        checks++;
        if (count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_full got count=%0d ovf=%b drop=%0d exp 0 0 0", count, overflow, drop_cnt);
        end
        push_seq(24'h000055, 1);
        checks++;
        if (out_valid !== 1'b1 || dout !== 24'h000055 || count !== 4'd1) begin
            errors++;
            $display("FAIL flush_after got valid=%b dout=%h count=%0d exp 1 000055 1", out_valid, dout, count);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_seq(24'h000031, 3);
        checks++;
        if (count !== 4'd3 || dout !== 24'h000031) begin
            errors++;
            $display("FAIL rstmid_pre got count=%0d dout=%h exp 3 000031", count, dout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || {empty, almost_empty, full, almost_full, out_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL rstmid_async got count=%0d flags=%b exp 0 11000", count, {empty, almost_empty, full, almost_full, out_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_release got valid=%b count=%0d exp 0 0", out_valid, count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_overflow();
        test_drain();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
